bus_arbiter_rr: RTL and testbench

//  Round-robin arbiter for the shared system bus. Up to four bus masters request it:
//  the IF-stage bus_if, the MEM-stage bus_if, and two spare ports (DMA/debug).

---
 rtl/bus_arbiter_rr_pkg.sv | 25 ++
 rtl/bus_arbiter_rr_pick.sv | 31 +++
 rtl/bus_arbiter_rr.sv | 123 ++++++++++++
 tb/tb_bus_arbiter_rr.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/bus_arbiter_rr_pkg.sv
// Shared bus-arbiter definitions: master count, owner index type, FSM states
// and the active-low enable levels used on the request/grant lines.
package bus_arbiter_rr_pkg;

  localparam int BUS_MASTER_CH = 4;

  typedef logic [1:0]               busOwner_t;
  typedef logic [BUS_MASTER_CH-1:0] busVec_t;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_OWNED  = 2'd1,
    ARB_REVOKE = 2'd2
  } arbState_t;

  localparam logic    ENABLE_   = 1'b0;
  localparam logic    DISABLE_  = 1'b1;
  localparam busVec_t GRNT_NONE = '1;

  // Active-low grant vector with only the given master's bit pulled low.
  function automatic busVec_t grantFor(input busOwner_t idx);
    return ~(busVec_t'(1) << idx);
  endfunction

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first eligible requester searching upward
// from lastOwner+1 with wrap, so lastOwner itself is considered last.
module rr_pick
  import bus_arbiter_rr_pkg::*;
(
  input  busVec_t   i_req,
  input  busOwner_t i_lastOwner,
  input  busVec_t   i_exclude,
  output logic      o_valid,
  output busOwner_t o_index
);

  busVec_t   w_eligible;
  busOwner_t w_cand;

  assign w_eligible = i_req & ~i_exclude;

  always_comb begin
    o_valid = 1'b0;
    o_index = i_lastOwner;
    w_cand  = i_lastOwner;
    for (int k = 1; k <= BUS_MASTER_CH; k++) begin
      w_cand = i_lastOwner + busOwner_t'(k);
      if (!o_valid && w_eligible[w_cand]) begin
        o_valid = 1'b1;
        o_index = w_cand;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter_rr.sv
// Round-robin system-bus arbiter for four masters with exclusive, held grants
// and a hold-limit timer that revokes an owner starving other requesters.
module bus_arbiter_rr
  import bus_arbiter_rr_pkg::*;
#(
  parameter int unsigned MAX_HOLD   = 64,
  parameter int unsigned HOLD_CNT_W = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] m_req_,
  output logic [3:0] m_grnt_,
  output logic [1:0] owner,
  output logic       bus_busy,
  output logic       hold_timeout
);

  localparam bit                    HOLD_EN   = (MAX_HOLD != 0);
  localparam logic [HOLD_CNT_W-1:0] HOLD_MAX  = HOLD_CNT_W'(MAX_HOLD);
  localparam logic [HOLD_CNT_W-1:0] HOLD_LAST = HOLD_EN ? HOLD_CNT_W'(MAX_HOLD - 1) : '0;

  arbState_t             r_state, w_nextState;
  busVec_t               r_grnt, w_nextGrnt;
  busOwner_t             r_owner, w_nextOwner;
  busOwner_t             r_lastOwner, w_nextLast;
  logic [HOLD_CNT_W-1:0] r_holdCnt, w_nextCnt;
  logic                  r_busy;
  logic                  r_timeout, w_nextTimeout;

  busVec_t   w_req;
  busOwner_t w_pickFrom;
  busVec_t   w_pickExclude;
  logic      w_pickValid;
  busOwner_t w_pickIdx;
  logic      w_ownerReleased;

  assign w_req           = ~m_req_;
  assign w_ownerReleased = (m_req_[r_owner] == DISABLE_);

  // While owned, search from the owner and ignore it, so pickValid also means "someone else waits".
  assign w_pickFrom    = (r_state == ARB_OWNED) ? r_owner : r_lastOwner;
  assign w_pickExclude = (r_state == ARB_OWNED) ? ~grantFor(r_owner) : '0;

  rr_pick u_pick (
    .i_req       (w_req),
    .i_lastOwner (w_pickFrom),
    .i_exclude   (w_pickExclude),
    .o_valid     (w_pickValid),
    .o_index     (w_pickIdx)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ARB_IDLE;
      r_grnt      <= GRNT_NONE;
      r_owner     <= '0;
      r_lastOwner <= busOwner_t'(BUS_MASTER_CH - 1);
      r_holdCnt   <= '0;
      r_busy      <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_state     <= w_nextState;
      r_grnt      <= w_nextGrnt;
      r_owner     <= w_nextOwner;
      r_lastOwner <= w_nextLast;
      r_holdCnt   <= w_nextCnt;
      r_busy      <= (w_nextGrnt != GRNT_NONE);
      r_timeout   <= w_nextTimeout;
    end
  end

  // A saturated counter still revokes as soon as a second requester appears.
  always_comb begin
    w_nextState   = r_state;
    w_nextGrnt    = r_grnt;
    w_nextOwner   = r_owner;
    w_nextLast    = r_lastOwner;
    w_nextCnt     = r_holdCnt;
    w_nextTimeout = 1'b0;
    case (r_state)
      ARB_IDLE, ARB_REVOKE: begin
        w_nextGrnt  = GRNT_NONE;
        w_nextState = ARB_IDLE;
        if (w_pickValid) begin
          w_nextGrnt  = grantFor(w_pickIdx);
          w_nextOwner = w_pickIdx;
          w_nextCnt   = '0;
          w_nextState = ARB_OWNED;
        end
      end
      ARB_OWNED: begin
        if (w_ownerReleased) begin
          w_nextLast = r_owner;
          if (w_pickValid) begin
            w_nextGrnt  = grantFor(w_pickIdx);
            w_nextOwner = w_pickIdx;
            w_nextCnt   = '0;
          end else begin
            w_nextGrnt  = GRNT_NONE;
            w_nextState = ARB_IDLE;
          end
        end else if (HOLD_EN && (r_holdCnt >= HOLD_LAST) && w_pickValid) begin
          w_nextGrnt    = GRNT_NONE;
          w_nextTimeout = 1'b1;
          w_nextLast    = r_owner;
          w_nextState   = ARB_REVOKE;
        end else if (r_holdCnt < HOLD_MAX) begin
          w_nextCnt = r_holdCnt + 1'b1;
        end
      end
      default: begin
        w_nextGrnt  = GRNT_NONE;
        w_nextState = ARB_IDLE;
      end
    endcase
  end

  assign m_grnt_      = r_grnt;
  assign owner        = r_owner;
  assign bus_busy     = r_busy;
  assign hold_timeout = r_timeout;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Directed bench for bus_arbiter_rr: vector table for grant/handoff/rotation,
// plus hand-written sequences for async reset, hold-limit revoke and saturation.
module tb_bus_arbiter_rr;

  logic       clk;
  logic       reset;
  logic [3:0] m_req_;
  logic [3:0] m_grnt_;
  logic [1:0] owner;
  logic       bus_busy;
  logic       hold_timeout;

  int assertCount;
  int failCount;

  typedef struct {
    logic       pulseReset;
    logic [3:0] req;
    logic [3:0] expGrnt;
    logic [1:0] expOwner;
    logic       expBusy;
    logic       expTmo;
  } vec_t;

  vec_t vecs[14];

  bus_arbiter_rr #(.MAX_HOLD(4), .HOLD_CNT_W(7)) dut (
    .clk          (clk),
    .reset        (reset),
    .m_req_       (m_req_),
    .m_grnt_      (m_grnt_),
    .owner        (owner),
    .bus_busy     (bus_busy),
    .hold_timeout (hold_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic [3:0] req);
    m_req_ = req;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [3:0] expGrnt,
                             input logic [1:0] expOwner, input logic expBusy,
                             input logic expTmo);
    assertCount++;
    if (m_grnt_ !== expGrnt || owner !== expOwner || bus_busy !== expBusy ||
        hold_timeout !== expTmo) begin
      failCount++;
      $display("[TB] FAIL %s: got grnt=%b owner=%0d busy=%b tmo=%b, expected grnt=%b owner=%0d busy=%b tmo=%b",
               name, m_grnt_, owner, bus_busy, hold_timeout, expGrnt, expOwner, expBusy, expTmo);
    end
  endtask

  task automatic resetDut();
    reset  = 1'b1;
    m_req_ = 4'b1111;
    #12;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    assertCount = 0;
    failCount   = 0;
    reset       = 1'b1;
    m_req_      = 4'b1111;

    // Single grant, same-edge handoff m0->m1, then release to idle; then four-way rotation.
    vecs[0]  = '{1'b1, 4'b1110, 4'b1110, 2'd0, 1'b1, 1'b0};
    vecs[1]  = '{1'b0, 4'b1100, 4'b1110, 2'd0, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, 4'b1101, 4'b1101, 2'd1, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 4'b1111, 4'b1111, 2'd1, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 4'b0000, 4'b1110, 2'd0, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 4'b0000, 4'b1110, 2'd0, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 4'b0001, 4'b1101, 2'd1, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 4'b0000, 4'b1101, 2'd1, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 4'b0010, 4'b1011, 2'd2, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 4'b0000, 4'b1011, 2'd2, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 4'b0100, 4'b0111, 2'd3, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 4'b0000, 4'b0111, 2'd3, 1'b1, 1'b0};
    vecs[12] = '{1'b0, 4'b1000, 4'b1110, 2'd0, 1'b1, 1'b0};
    vecs[13] = '{1'b0, 4'b1111, 4'b1111, 2'd0, 1'b0, 1'b0};

    #3;
    checkOutput("resetValues", 4'b1111, 2'd0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 14; i++) begin
      if (vecs[i].pulseReset) resetDut();
      applyStimulus(vecs[i].req);
      checkOutput($sformatf("vec%0d", i), vecs[i].expGrnt, vecs[i].expOwner,
                  vecs[i].expBusy, vecs[i].expTmo);
    end

    // Async reset while m1 owns the bus: grants drop with no clock edge.
    resetDut();
    applyStimulus(4'b1101);
    checkOutput("preResetGrant", 4'b1101, 2'd1, 1'b1, 1'b0);
    #2 reset = 1'b1;
    #1;
    checkOutput("midGrantReset", 4'b1111, 2'd0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(4'b1111);
    checkOutput("idleAfterReset", 4'b1111, 2'd0, 1'b0, 1'b0);

    // Hold limit: m0 holds 4 grant cycles while m2 waits, dead cycle, then m2.
    resetDut();
    applyStimulus(4'b1110);
    checkOutput("holdGrant0", 4'b1110, 2'd0, 1'b1, 1'b0);
    for (int c = 1; c <= 3; c++) begin
      applyStimulus(4'b1010);
      checkOutput($sformatf("holdGrant%0d", c), 4'b1110, 2'd0, 1'b1, 1'b0);
    end
    applyStimulus(4'b1010);
    checkOutput("revokePulse", 4'b1111, 2'd0, 1'b0, 1'b1);
    applyStimulus(4'b1010);
    checkOutput("grantAfterRevoke", 4'b1011, 2'd2, 1'b1, 1'b0);

    // Revoked master is re-granted when it becomes the sole requester.
    resetDut();
    applyStimulus(4'b1110);
    for (int c = 1; c <= 3; c++) applyStimulus(4'b1010);
    applyStimulus(4'b1010);
    checkOutput("revokePulse2", 4'b1111, 2'd0, 1'b0, 1'b1);
    applyStimulus(4'b1110);
    checkOutput("soleRevokedRegrant", 4'b1110, 2'd0, 1'b1, 1'b0);

    // Lone owner never revoked; counter parks at the limit.
    resetDut();
    for (int c = 0; c < 20; c++) begin
      applyStimulus(4'b1110);
      checkOutput($sformatf("lone%0d", c), 4'b1110, 2'd0, 1'b1, 1'b0);
    end
    assertCount++;
    if (dut.r_holdCnt !== 7'd4) begin
      failCount++;
      $display("[TB] FAIL holdCntSaturate: got %0d, expected 4", dut.r_holdCnt);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
